// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and defaults for the multiply/divide unit
//
// Purpose: op codes used by the decoder and the MDU, the scheduler state
// type and the default multiply/divide latencies.
// Ports: none (package).

package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MDU_MUL_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational HI/LO result generator for MULT/MULTU/DIV/DIVU
//
// Purpose: computes the 64-bit {hi,lo} result of a multiply or divide from
// the operands. Purely combinational; the scheduler latches the result.
// Configuration: the divide path exists only when MDU_DIV_EN is defined;
// otherwise DIV/DIVU produce zero and no divider is built.
// Ports:
//   op      in  3  : MDU op code (mdu_pkg encoding)
//   rs_val  in  32 : rs operand (dividend / multiplicand)
//   rt_val  in  32 : rt operand (divisor / multiplier)
//   hi      out 32 : product high word or remainder
//   lo      out 32 : product low word or quotient

module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // A 64x64 product of the sign-extended operands has the exact signed
    // 64-bit product in its low half, so no signed arithmetic is needed.
    always_comb begin
        prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u = {32'b0, rs_val} * {32'b0, rt_val};
    end

`ifdef MDU_DIV_EN
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Signed divide is done on magnitudes: quotient is negated when the
    // signs differ (truncation toward zero) and the remainder follows the
    // dividend's sign. 0x80000000 / -1 falls out as 0x80000000, remainder 0.
    always_comb begin
        rs_neg = (op == MDU_DIV) && rs_val[31];
        rt_neg = (op == MDU_DIV) && rt_val[31];
        rs_mag = rs_neg ? (32'd0 - rs_val) : rs_val;
        rt_mag = rt_neg ? (32'd0 - rt_val) : rt_val;
        q_mag  = '0;
        r_mag  = '0;
        if (rt_mag != 32'd0) begin
            q_mag = rs_mag / rt_mag;
            r_mag = rs_mag % rt_mag;
        end
        quot = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
        rem  = rs_neg ? (32'd0 - r_mag) : r_mag;
    end
`endif

    always_comb begin
        hi = '0;
        lo = '0;
        case (op)
            MDU_MULT: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
            end
`ifdef MDU_DIV_EN
            MDU_DIV, MDU_DIVU: begin
                hi = rem;
                lo = quot;
            end
`endif
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - multiply/divide scheduler owning HI/LO and the MDU stall
//
// Purpose: accepts MDU ops from E, runs MULT/MULTU/DIV/DIVU for a fixed
// latency, commits results to HI/LO, handles MTHI/MTLO immediately and
// raises the D-stage stall for HI/LO-touching instructions.
// Configuration: MDU_DIV_EN enables DIV/DIVU; undefined, they are no-ops.
// Ports:
//   clk        in  1  : clock, rising edge
//   clr        in  1  : synchronous active-high reset
//   start      in  1  : E-stage instruction is an MDU op
//   op         in  3  : MDU op code (mdu_pkg encoding)
//   rs_val     in  32 : forwarded rs
//   rt_val     in  32 : forwarded rt
//   d_uses_md  in  1  : D-stage instruction is an MDU op or MFHI/MFLO
//   busy       out 1  : multiply/divide in flight
//   stall_md   out 1  : stall request for the pipeline
//   hi         out 32 : architectural HI
//   lo         out 32 : architectural LO

module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

`ifdef MDU_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               commit_q, commit_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               is_mul;
    logic               is_div;

    mdu_arith u_arith (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi     (res_hi),
        .lo     (res_lo)
    );

    always_comb begin
        is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
        is_div = DIV_EN && ((op == MDU_DIV) || (op == MDU_DIVU));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        commit_d  = commit_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        pend_hi_d = res_hi;
                        pend_lo_d = res_lo;
                        commit_d  = 1'b1;
                        cnt_d     = CNT_W'(MUL_CYCLES);
                        state_d   = ST_BUSY;
                    end else if (is_div) begin
                        pend_hi_d = res_hi;
                        pend_lo_d = res_lo;
                        // Divide by zero still occupies the unit but
                        // leaves HI/LO untouched at completion.
                        commit_d  = (rt_val != 32'd0);
                        cnt_d     = CNT_W'(DIV_CYCLES);
                        state_d   = ST_BUSY;
                    end else if (op == MDU_MTHI) begin
                        hi_d = rs_val;
                    end else if (op == MDU_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            ST_BUSY: begin
                // start is ignored here; the stall keeps it from happening.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                    commit_d = 1'b0;
                    if (commit_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            commit_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            commit_q  <= commit_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        busy     = (state_q == ST_BUSY);
        stall_md = d_uses_md & (busy | start);
        hi       = hi_q;
        lo       = lo_q;
    end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide scheduler for the pipelined MIPS datapath. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the HI/LO registers. Runs each multiply or divide for a fixed multi-cycle latency and reports busy. Generates the stall request that holds any HI/LO-touching instruction in D until the unit is free.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk` in 1: the single clock; everything updates on the rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `start` in 1: the E-stage instruction is an MDU op this cycle.
- `op` in 3: MDU op code from `mdu_pkg` (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- `rs_val` in 32: forwarded rs operand.
- `rt_val` in 32: forwarded rt operand.
- `d_uses_md` in 1: the D-stage instruction is an MDU op or MFHI/MFLO.
- `busy` out 1: a multiply/divide is in flight.
- `stall_md` out 1: stall request, ORed into the pipeline stall.
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.

## Operation
- States: IDLE and BUSY. There is also a down-counter `cnt`, 4 bits minimum, sized to cover `max(MUL_CYCLES, DIV_CYCLES)`.
- In IDLE, with `start` high:
  - MULT/MULTU: latch the 64-bit product into `pend_hi`/`pend_lo`. MULT is signed, MULTU is unsigned. Load `cnt = MUL_CYCLES`, go to BUSY.
  - DIV/DIVU: latch quotient into `pend_lo` and remainder into `pend_hi`. Quotient truncates toward zero; the remainder takes the sign of the dividend. Load `cnt = DIV_CYCLES`, go to BUSY.
  - Divide by zero (`rt_val == 0`): accepted and busy for `DIV_CYCLES`. HI/LO are left unchanged at completion.
  - MTHI/MTLO: write `rs_val` into HI/LO at this edge. Stay in IDLE; `busy` does not rise.
- In BUSY:
  - `cnt` decrements each cycle.
  - When `cnt == 1`, the edge commits `pend_hi`/`pend_lo` to HI/LO (unless the op was a divide by zero). `busy` falls and the state returns to IDLE.
- `start` while BUSY is a protocol violation, because `stall_md` prevents it. The unit ignores it: no state change and no HI/LO write.
- `stall_md = d_uses_md & (busy | start)`. This is combinational and has no other terms.
- `hi` and `lo` are register outputs and never show pending values.
- `clr` takes priority over everything:
  - state goes to IDLE, `cnt = 0`;
  - `busy = 0`, `hi = 0`, `lo = 0`, `pend_* = 0`;
  - an in-flight operation is discarded without committing;
  - a `start` in the same cycle as `clr` is dropped.

## Timing
- `start` sampled at edge T0: `busy` is high from T0+1 through T0+N, where N is the op's latency.
- HI/LO hold the new values from T0+N+1. In that same cycle `busy` is 0.
- A back-to-back `start` is accepted in the first cycle where `busy = 0`, i.e. T0+N+1.
- MTHI/MTLO at T0: the new value is visible from T0+1. A following MTHI/MTLO at T0+1 is also accepted.
- `stall_md` is asserted in the same cycle as `start` when D uses the MDU. This covers the back-to-back MDU-op hazard with no bubble lost.
- Reset values of all outputs: `busy = 0`, `stall_md = 0` while `d_uses_md = 0`, `hi = 0`, `lo = 0`.

## Configuration
- `MDU_DIV_EN` defined:
  - DIV/DIVU are implemented as described above.
- `MDU_DIV_EN` undefined:
  - DIV/DIVU are treated as no-ops: no busy cycles, no HI/LO change.
  - No divider logic is synthesized.
  - MULT/MULTU/MTHI/MTLO are unchanged.

## Structure
- `mdu_pkg` holds:
  - the `op` encodings (MULT = 0, MULTU = 1, DIV = 2, DIVU = 3, MTHI = 4, MTLO = 5);
  - the state enum;
  - the default latency constants.
- The decoder that produces `start`, `op` and `d_uses_md` stays in the existing control unit and reuses the same package encodings.
- One sub-module, `mdu_arith`, is combinational. It computes `{hi,lo}` from `op`, `rs_val` and `rt_val`. Its divide path is guarded by `MDU_DIV_EN`.
- `mdu_sched` contains the FSM, counter, pending registers, HI/LO registers and stall logic.

## Test plan
- Reset mid-op: `clr` at T0+3 of a MULT -> `busy = 0` and `hi = lo = 0` from the next edge; the stale result never appears.
- MULT with rs = 0xFFFFFFFF, rt = 2 at T0 -> `busy` is high for exactly 5 cycles. At T0+6, `hi` = 0xFFFFFFFF and `lo` = 0xFFFFFFFE.
- MULTU with the same operands -> `hi` = 0x00000001, `lo` = 0xFFFFFFFE after 5 busy cycles.
- DIV with rs = 0xFFFFFFF9 (-7), rt = 2 -> after 10 busy cycles, `lo` = 0xFFFFFFFD and `hi` = 0xFFFFFFFF.
- DIVU 7/2 -> `lo` = 3, `hi` = 1.
- Divide by zero -> `busy` is high for 10 cycles and HI/LO are unchanged.
- MTHI with 0x12345678 at T0 -> `hi` = 0x12345678 at T0+1 and `busy` stays 0.
- MFLO held in D during a MULT -> `stall_md` is high from the `start` cycle through the last busy cycle and low at T0+6.
- Build without `MDU_DIV_EN` and issue DIV -> `busy` stays 0 and HI/LO are unchanged.
